// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, mismatch kinds and
// width helpers for the trace checker.
package trace_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_ACC  = 2'b01;
  localparam logic [1:0] KIND_PC   = 2'b10;
  localparam logic [1:0] KIND_BOTH = 2'b11;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trace_checker_if.sv
// trace_checker_if: memory load bus shared by the
// instruction image and the expected-trace store.
interface trace_checker_if
  import trace_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TRC_AW = 8
);
  localparam int LD_AW = max_w(ADDR_W, TRC_AW);

  logic                     ld_we;
  logic                     ld_sel;
  logic [LD_AW-1:0]         ld_addr;
  logic [ADDR_W+DATA_W-1:0] ld_data;

  modport master (
    output ld_we, ld_sel, ld_addr, ld_data
  );

  modport slave (
    input ld_we, ld_sel, ld_addr, ld_data
  );

endinterface

// File: rtl/trace_ram.sv
// trace_ram: simple RAM, synchronous write and
// asynchronous read; contents survive reset.
module trace_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // write port, no reset so images persist
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_checker.sv
// trace_checker: feeds INST from the instruction image and
// checks the core's PC/ACC against an expected trace.
module trace_checker
  import trace_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int TRC_AW      = 8,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [ADDR_W-1:0] PC,
  input  logic [DATA_W-1:0] ACC,
  output logic [DATA_W-1:0] INST,
  input  logic              start,
  input  logic [TRC_AW:0]   trace_len,
  trace_checker_if.slave    ld,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [TRC_AW-1:0] fail_idx,
  output logic [ADDR_W-1:0] fail_pc,
  output logic [DATA_W-1:0] fail_acc,
  output logic [1:0]        fail_kind
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
  } entry_t;

  localparam int EW = ADDR_W + DATA_W;
  localparam logic [TRC_AW-1:0] IDX_ONE = TRC_AW'(1);
  localparam logic [TRC_AW:0]   LEN_ONE = (TRC_AW + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [1:0]        state;
  logic [TRC_AW-1:0] idx;
  logic [TRC_AW:0]   len;
  logic [EW-1:0]     trc_rd;
  entry_t            exp_e;
  logic              ld_ok;
  logic              pc_bad;
  logic              acc_bad;
  logic              mis;
  logic              last;
  logic              first;

  assign ld_ok = ld.ld_we && (state != ST_RUN);

  trace_ram #(.AW(ADDR_W), .DW(DATA_W)) u_imem (
    .clk   (CLK),
    .we    (ld_ok && !ld.ld_sel),
    .waddr (ld.ld_addr[ADDR_W-1:0]),
    .wdata (ld.ld_data[DATA_W-1:0]),
    .raddr (PC),
    .rdata (INST)
  );

  trace_ram #(.AW(TRC_AW), .DW(EW)) u_trc (
    .clk   (CLK),
    .we    (ld_ok && ld.ld_sel),
    .waddr (ld.ld_addr[TRC_AW-1:0]),
    .wdata (ld.ld_data),
    .raddr (idx),
    .rdata (trc_rd)
  );

  assign exp_e   = entry_t'(trc_rd);
  assign pc_bad  = exp_e.pc != PC;
  assign acc_bad = exp_e.acc != ACC;
  assign mis     = pc_bad || acc_bad;
  assign last    = {1'b0, idx} == (len - LEN_ONE);
  assign first   = fail_kind == KIND_NONE;

  assign busy = state == ST_RUN;
  assign done = (state == ST_DONE) || (state == ST_FAIL);
  assign pass = done && (err_cnt == '0);

  // run control, compare, error count and first-fail capture
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len       <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_pc   <= '0;
      fail_acc  <= '0;
      fail_kind <= KIND_NONE;
    end else begin
      unique case (1'b1)
        busy: begin
          if (mis) begin
            if (!(&err_cnt)) err_cnt <= err_cnt + CNT_ONE;
            if (first) begin
              fail_idx  <= idx;
              fail_pc   <= PC;
              fail_acc  <= ACC;
              fail_kind <= {pc_bad, acc_bad};
            end
          end
          if (STOP_ON_ERR && mis) begin
            state <= ST_FAIL;
          end else begin
            idx <= idx + IDX_ONE;
            if (last) state <= ST_DONE;
          end
        end
        (!busy && start): begin
          len       <= trace_len;
          idx       <= '0;
          err_cnt   <= '0;
          fail_idx  <= '0;
          fail_pc   <= '0;
          fail_acc  <= '0;
          fail_kind <= KIND_NONE;
          state     <= (trace_len == '0) ? ST_DONE : ST_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule
